stress_trend: RTL and testbench

STRESS_TREND -- requirements
Module: stress_trend

---
 rtl/stress_trend.sv | 150 +++++++++++++++
 tb/tb_stress_trend.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stress_trend.sv
// Multi-channel stress trend detector: per-channel windowed averages are compared
// window-to-window and combined into a decreased/unchanged/increased verdict on each tick.
module stress_trend #(
  parameter int N_CH      = 2,
  parameter int W         = 8,
  parameter int AVG_SHIFT = 2,
  parameter int TOL       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic [N_CH*W-1:0] ch_data,
  input  logic [N_CH-1:0]   ch_valid,
  input  logic              clear,
  input  logic              mode,
  output logic [N_CH-1:0]   ch_laag,
  output logic [N_CH-1:0]   ch_gelijk,
  output logic              gedaald,
  output logic              gelijk,
  output logic              gestegen,
  output logic              trend_valid
);

  localparam int ACC_W = W + AVG_SHIFT;
  localparam int CNT_W = AVG_SHIFT + 1;
  localparam int CW    = $clog2(N_CH + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_SHIFT) - 1);
  localparam logic signed [W:0] TOL_S   = (W+1)'(TOL);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] track;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [ACC_W-1:0] acc_q, acc_d, sum;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [W-1:0]     cur_q, cur_d, prev_q, prev_d;
      logic [1:0]       st_q, st_d;
      logic signed [W:0] diff;

      assign sum = acc_q + ACC_W'(ch_data[gi*W +: W]);

      always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        cur_d  = cur_q;
        prev_d = prev_q;
        st_d   = st_q;
        if (ch_valid[gi]) begin
          if (cnt_q == CNT_LAST) begin
            acc_d  = '0;
            cnt_d  = '0;
            cur_d  = sum[ACC_W-1:AVG_SHIFT];
            prev_d = cur_q;
            st_d   = (st_q == ST_EMPTY) ? ST_ONE : ST_TRACK;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          acc_q  <= '0;
          cnt_q  <= '0;
          cur_q  <= '0;
          prev_q <= '0;
          st_q   <= ST_EMPTY;
        end else if (clear) begin
          acc_q  <= '0;
          cnt_q  <= '0;
          cur_q  <= '0;
          prev_q <= '0;
          st_q   <= ST_EMPTY;
        end else begin
          acc_q  <= acc_d;
          cnt_q  <= cnt_d;
          cur_q  <= cur_d;
          prev_q <= prev_d;
          st_q   <= st_d;
        end
      end

      // Flags derive purely from registered cur/prev, so they change only when a window completes.
      assign diff          = $signed({1'b0, cur_q}) - $signed({1'b0, prev_q});
      assign track[gi]     = (st_q == ST_TRACK);
      assign ch_laag[gi]   = track[gi] && (diff < -TOL_S);
      assign ch_gelijk[gi] = track[gi] && (diff >= -TOL_S) && (diff <= TOL_S);
      assign rise[gi]      = track[gi] && (diff > TOL_S);
    end
  endgenerate

  logic [CW-1:0] n_laag, n_gel, n_rise, n_trk;
  logic          ged_d, gel_d, ges_d, tv_d;
  logic          ged_q, gel_q, ges_q, tv_q;

  always_comb begin
    n_laag = '0;
    n_gel  = '0;
    n_rise = '0;
    n_trk  = '0;
    for (int k = 0; k < N_CH; k++) begin
      n_laag = n_laag + CW'(ch_laag[k]);
      n_gel  = n_gel  + CW'(ch_gelijk[k]);
      n_rise = n_rise + CW'(rise[k]);
      n_trk  = n_trk  + CW'(track[k]);
    end
    tv_d = (n_trk != '0);
    if (mode) begin
      // Strict majority of tracked channels; with no tracked channels every count is 0.
      ged_d = ({n_laag, 1'b0} > {1'b0, n_trk});
      gel_d = ({n_gel,  1'b0} > {1'b0, n_trk});
      ges_d = ({n_rise, 1'b0} > {1'b0, n_trk});
    end else begin
      ged_d = |ch_laag;
      gel_d = |ch_gelijk;
      ges_d = |rise;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ged_q <= 1'b0;
      gel_q <= 1'b0;
      ges_q <= 1'b0;
      tv_q  <= 1'b0;
    end else if (clear) begin
      ged_q <= 1'b0;
      gel_q <= 1'b0;
      ges_q <= 1'b0;
      tv_q  <= 1'b0;
    end else if (sample_tick) begin
      ged_q <= ged_d;
      gel_q <= gel_d;
      ges_q <= ges_d;
      tv_q  <= tv_d;
    end
  end

  assign gedaald     = ged_q;
  assign gelijk      = gel_q;
  assign gestegen    = ges_q;
  assign trend_valid = tv_q;

endmodule

// File: tb/tb_stress_trend.sv
// Scoreboard bench for stress_trend: stimulus queues expected responses, a monitor
// pops and compares them one cycle after each tick or on an explicit snapshot.
module tb_stress_trend;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic [15:0] ch_data;
  logic [1:0]  ch_valid;
  logic        clear;
  logic        mode;
  logic [1:0]  ch_laag, ch_gelijk;
  logic        gedaald, gelijk, gestegen, trend_valid;

  stress_trend #(.N_CH(2), .W(8), .AVG_SHIFT(2), .TOL(4)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .ch_data(ch_data),
    .ch_valid(ch_valid), .clear(clear), .mode(mode), .ch_laag(ch_laag),
    .ch_gelijk(ch_gelijk), .gedaald(gedaald), .gelijk(gelijk),
    .gestegen(gestegen), .trend_valid(trend_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] laag;
    logic [1:0] gel;
    logic       ged, gl, gs, tv;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic snap_req = 1'b0;

  task automatic chk(string nm, int act, int want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  task automatic compare(logic [1:0] l, logic [1:0] g);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_underflow", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({e.name, "/ch_laag"},     int'(l),           int'(e.laag));
    chk({e.name, "/ch_gelijk"},   int'(g),           int'(e.gel));
    chk({e.name, "/gedaald"},     int'(gedaald),     int'(e.ged));
    chk({e.name, "/gelijk"},      int'(gelijk),      int'(e.gl));
    chk({e.name, "/gestegen"},    int'(gestegen),    int'(e.gs));
    chk({e.name, "/trend_valid"}, int'(trend_valid), int'(e.tv));
    $display("check %s: laag=%b gel=%b ged=%b gl=%b gs=%b tv=%b", e.name, l, g,
             gedaald, gelijk, gestegen, trend_valid);
  endtask

  // Monitor: per-channel flags are captured in the tick cycle, combined outputs one cycle later.
  initial begin
    logic       tick_pend;
    logic [1:0] cap_l, cap_g;
    tick_pend = 1'b0;
    cap_l = '0;
    cap_g = '0;
    forever begin
      @(negedge clk);
      if (tick_pend) begin
        compare(cap_l, cap_g);
        tick_pend = 1'b0;
      end
      if (sample_tick) begin
        cap_l = ch_laag;
        cap_g = ch_gelijk;
        tick_pend = 1'b1;
      end
      if (snap_req) compare(ch_laag, ch_gelijk);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string nm, logic [1:0] l, logic [1:0] g, logic ged, logic gl,
                      logic gs, logic tv);
    exp_t e;
    e.name = nm; e.laag = l; e.gel = g; e.ged = ged; e.gl = gl; e.gs = gs; e.tv = tv;
    exp_q.push_back(e);
  endtask

  task automatic snap(string nm, logic [1:0] l, logic [1:0] g, logic ged, logic gl,
                      logic gs, logic tv);
    push(nm, l, g, ged, gl, gs, tv);
    snap_req = 1'b1;
    cyc();
    snap_req = 1'b0;
  endtask

  task automatic tick(string nm, logic [1:0] l, logic [1:0] g, logic ged, logic gl,
                      logic gs, logic tv);
    push(nm, l, g, ged, gl, gs, tv);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic feed(int ch, int val, int n);
    for (int i = 0; i < n; i++) begin
      ch_valid = 2'b01 << ch;
      ch_data[ch*8 +: 8] = 8'(val);
      cyc();
    end
    ch_valid = 2'b00;
  endtask

  task automatic feed2(int v0, int v1, int n);
    for (int i = 0; i < n; i++) begin
      ch_valid = 2'b11;
      ch_data  = {8'(v1), 8'(v0)};
      cyc();
    end
    ch_valid = 2'b00;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sample_tick = 1'b0; ch_data = '0; ch_valid = '0; clear = 1'b0; mode = 1'b0;
    cyc();
    snap("reset_hold", 2'b00, 2'b00, 0, 0, 0, 0);
    reset = 1'b1;
    cyc();

    // Fall 100 -> 90 on ch0
    feed(0, 100, 4);
    feed(0, 90, 4);
    tick("fall", 2'b01, 2'b00, 1, 0, 0, 1);
    do_clear();
    snap("clear", 2'b00, 2'b00, 0, 0, 0, 0);

    // Tolerance band
    feed(0, 100, 4);
    feed(0, 103, 4);
    tick("tol_103", 2'b00, 2'b01, 0, 1, 0, 1);
    feed(0, 107, 4);
    tick("tol_107", 2'b00, 2'b01, 0, 1, 0, 1);
    do_clear();
    feed(0, 103, 4);
    feed(0, 108, 4);
    tick("tol_108", 2'b00, 2'b00, 0, 0, 1, 1);

    // Combine modes
    do_clear();
    feed2(100, 50, 4);
    feed2(90, 60, 4);
    tick("mode0", 2'b01, 2'b00, 1, 0, 1, 1);
    mode = 1'b1;
    snap("mode_hold", 2'b01, 2'b00, 1, 0, 1, 1);
    tick("mode1_split", 2'b01, 2'b00, 0, 0, 0, 1);
    do_clear();
    feed2(100, 100, 4);
    feed2(90, 90, 4);
    tick("mode1_major", 2'b11, 2'b00, 1, 0, 0, 1);
    mode = 1'b0;

    // Partial window discarded by reset
    feed(0, 200, 2);
    reset = 1'b0;
    snap("mid_reset", 2'b00, 2'b00, 0, 0, 0, 0);
    reset = 1'b1;
    cyc();
    feed(0, 100, 4);
    tick("one_window", 2'b00, 2'b00, 0, 0, 0, 0);
    feed(0, 100, 4);
    tick("partial", 2'b00, 2'b01, 0, 1, 0, 1);

    // Window completing on the tick cycle is seen only at the next tick
    feed(0, 110, 3);
    push("simul_tick", 2'b00, 2'b01, 0, 1, 0, 1);
    ch_valid = 2'b01;
    ch_data[7:0] = 8'd110;
    sample_tick = 1'b1;
    cyc();
    ch_valid = 2'b00;
    sample_tick = 1'b0;
    cyc();
    cyc();
    tick("after_simul", 2'b00, 2'b00, 0, 0, 1, 1);

    // Clear beats ch_valid: the sample of 50 must be dropped
    clear = 1'b1;
    ch_valid = 2'b01;
    ch_data[7:0] = 8'd50;
    cyc();
    clear = 1'b0;
    ch_valid = 2'b00;
    snap("clear_valid", 2'b00, 2'b00, 0, 0, 0, 0);
    feed(0, 70, 4);
    feed(0, 70, 4);
    tick("drop_check", 2'b00, 2'b01, 0, 1, 0, 1);

    repeat (3) cyc();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
